// File: rtl/dda_pkg.sv
// Shared definitions for the DDA run controller: state encoding, command map
// and the bit layout of the command and status words.
package dda_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RESTART = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  localparam logic [7:0] CMD_START   = 8'h01;
  localparam logic [7:0] CMD_K1      = 8'h02;
  localparam logic [7:0] CMD_K2      = 8'h03;
  localparam logic [7:0] CMD_KM      = 8'h04;
  localparam logic [7:0] CMD_X1      = 8'h05;
  localparam logic [7:0] CMD_V1      = 8'h06;
  localparam logic [7:0] CMD_X2      = 8'h07;
  localparam logic [7:0] CMD_V2      = 8'h08;
  localparam logic [7:0] CMD_STOP    = 8'h09;
  localparam logic [7:0] CMD_SET_DIV = 8'h0A;
  localparam logic [7:0] CMD_CLR_ERR = 8'h0B;

  localparam logic [6:0] MASK_FULL = 7'h7F;
  localparam int         NUM_PARAMS = 7;

  localparam int CMD_ADDR_LSB   = 24;
  localparam int CMD_TOGGLE_BIT = 23;
  localparam int CMD_DATA_W     = 18;

  localparam int ST_STATE_LSB = 30;
  localparam int ST_MASK_LSB  = 23;
  localparam int ST_ERR_BIT   = 22;
  localparam int ST_ACK_BIT   = 21;

  typedef struct packed {
    logic [1:0]  state;
    logic [6:0]  mask;
    logic        err;
    logic        ack;
    logic [4:0]  rsvd;
    logic [15:0] count;
  } status_t;

  function automatic logic is_param_addr(input logic [7:0] addr);
    return (addr >= CMD_K1) && (addr <= CMD_V2);
  endfunction

endpackage

// File: rtl/dda_pos_sampler.sv
// Decimates the two DDA positions into a packed 32-bit word; the divider
// value is only picked up at a terminal count or on clear.
module dda_pos_sampler
  import dda_pkg::*;
#(
  parameter int               DW        = 18,
  parameter int               DIV_W     = 16,
  parameter logic [DIV_W-1:0] DIV_RESET = 16'd1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  input  logic [DW-1:0]    x1,
  input  logic [DW-1:0]    x2,
  output logic [31:0]      pos_word,
  output logic [15:0]      sample_count
);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_act;
  logic             terminal;

  assign terminal = (div_cnt == div_act - DIV_W'(1));

  logic unused_lsbs;
  assign unused_lsbs = ^{x1[DW-17:0], x2[DW-17:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt      <= '0;
      div_act      <= DIV_RESET;
      pos_word     <= '0;
      sample_count <= '0;
    end else if (clear) begin
      div_cnt <= '0;
      div_act <= div;
    end else if (enable) begin
      if (terminal) begin
        div_cnt      <= '0;
        div_act      <= div;
        // Top 16 bits of each position, plain truncation.
        pos_word     <= {x1[DW-1 -: 16], x2[DW-1 -: 16]};
        sample_count <= sample_count + 16'd1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/dda_run_ctrl.sv
// Command-driven run controller for the two-mass DDA: shadow parameter bank,
// atomic apply at restart, restart/run/hold sequencing and position sampling.
module dda_run_ctrl
  import dda_pkg::*;
#(
  parameter int               DW             = 18,
  parameter int               RESTART_CYCLES = 4,
  parameter int               DIV_W          = 16,
  parameter logic [DIV_W-1:0] DIV_RESET      = 16'd1000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [31:0]   cmd_word,
  input  logic [DW-1:0] x1,
  input  logic [DW-1:0] x2,
  output logic          dda_restart,
  output logic          dda_run,
  output logic [DW-1:0] k1_act,
  output logic [DW-1:0] k2_act,
  output logic [DW-1:0] km_act,
  output logic [DW-1:0] x1_act,
  output logic [DW-1:0] v1_act,
  output logic [DW-1:0] x2_act,
  output logic [DW-1:0] v2_act,
  output logic [31:0]   pos_word,
  output logic [31:0]   status_word
);

  localparam int RC_W = $clog2(RESTART_CYCLES + 1);

  logic             toggle_q;
  logic             cmd_valid;
  logic [7:0]       addr;
  logic [DW-1:0]    data;
  logic [2:0]       param_idx;

  logic [DW-1:0]    shadow [NUM_PARAMS];
  logic [DW-1:0]    act    [NUM_PARAMS];
  logic [6:0]       mask;
  logic             err;
  logic             ack;
  logic [1:0]       state;
  logic [RC_W-1:0]  rst_cnt;
  logic [DIV_W-1:0] div_reg;
  logic [15:0]      sample_count;

  logic is_start, is_stop, is_param, is_div, is_clr, is_bad;
  logic start_go, start_refused;

  // A command is any edge on the toggle bit; the word is stable around it.
  assign cmd_valid = cmd_word[CMD_TOGGLE_BIT] ^ toggle_q;
  assign addr      = cmd_word[31:CMD_ADDR_LSB];
  assign data      = DW'(cmd_word[CMD_DATA_W-1:0]);
  assign param_idx = 3'(addr - CMD_K1);

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^cmd_word[CMD_TOGGLE_BIT-1:CMD_DATA_W];

  assign is_start = cmd_valid && (addr == CMD_START);
  assign is_stop  = cmd_valid && (addr == CMD_STOP);
  assign is_param = cmd_valid && is_param_addr(addr);
  assign is_div   = cmd_valid && (addr == CMD_SET_DIV);
  assign is_clr   = cmd_valid && (addr == CMD_CLR_ERR);
  assign is_bad   = cmd_valid && ((addr == 8'h00) || (addr > CMD_CLR_ERR));

  // START during RESTART is swallowed; outside IDLE the mask is always full.
  assign start_go      = is_start && (mask == MASK_FULL) && (state != ST_RESTART);
  assign start_refused = is_start && (mask != MASK_FULL) && (state == ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q <= 1'b0;
      ack      <= 1'b0;
      err      <= 1'b0;
      mask     <= '0;
      state    <= ST_IDLE;
      rst_cnt  <= '0;
      div_reg  <= DIV_RESET;
      for (int i = 0; i < NUM_PARAMS; i++) begin
        shadow[i] <= '0;
        act[i]    <= '0;
      end
    end else begin
      toggle_q <= cmd_word[CMD_TOGGLE_BIT];
      if (cmd_valid) ack <= cmd_word[CMD_TOGGLE_BIT];

      if (is_param) begin
        shadow[param_idx] <= data;
        mask[param_idx]   <= 1'b1;
      end

      if (is_div) begin
        div_reg <= (data[DIV_W-1:0] == '0) ? DIV_W'(1) : data[DIV_W-1:0];
      end

      if (is_clr) err <= 1'b0;
      else if (is_bad || start_refused) err <= 1'b1;

      if (start_go) begin
        for (int i = 0; i < NUM_PARAMS; i++) act[i] <= shadow[i];
        rst_cnt <= RC_W'(RESTART_CYCLES);
        state   <= ST_RESTART;
      end else begin
        case (state)
          ST_RESTART: begin
            if (rst_cnt == RC_W'(1)) state <= ST_RUN;
            else rst_cnt <= rst_cnt - RC_W'(1);
          end
          ST_RUN: if (is_stop) state <= ST_HOLD;
          default: ;
        endcase
      end
    end
  end

  assign dda_restart = (state == ST_RESTART);
  assign dda_run     = (state == ST_RUN);

  assign k1_act = act[0];
  assign k2_act = act[1];
  assign km_act = act[2];
  assign x1_act = act[3];
  assign v1_act = act[4];
  assign x2_act = act[5];
  assign v2_act = act[6];

  dda_pos_sampler #(
    .DW        (DW),
    .DIV_W     (DIV_W),
    .DIV_RESET (DIV_RESET)
  ) u_sampler (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (state == ST_RUN),
    .clear        (start_go),
    .div          (div_reg),
    .x1           (x1),
    .x2           (x2),
    .pos_word     (pos_word),
    .sample_count (sample_count)
  );

  status_t status;
  always_comb begin
    status       = '0;
    status.state = state;
    status.mask  = mask;
    status.err   = err;
    status.ack   = ack;
    status.count = sample_count;
  end
  assign status_word = status;

endmodule

// File: doc/dda_run_ctrl.md
Name: dda_run_ctrl

Overview:
Command-driven controller between the Nios init PIO and the two-mass DDA. It decodes toggle-strobed command words into a shadow parameter bank and applies all seven parameters atomically at restart. It sequences the DDA through restart, run and hold, and decimates DDA positions for the position PIO. A status word lets software poll for acknowledgements and errors.

Parameters:
DW, 18, width of DDA parameters and positions
RESTART_CYCLES, 4, restart pulse length in clk cycles (>=1)
DIV_W, 16, width of sample-divider register
DIV_RESET, 16'd1000, sample divider value after reset

Ports:
clk  in  1  system clock, 50 MHz; Nios and DDA share this clock
reset_n  in  1  asynchronous, active-low reset
cmd_word  in  32  Nios PIO: [31:24] addr, [23] toggle strobe, [17:0] data
x1  in  DW  DDA position 1
x2  in  DW  DDA position 2
dda_restart  out  1  restart to the DDA
dda_run  out  1  high in RUN; gates the DDA clock-enable
k1_act, k2_act, km_act, x1_act, v1_act, x2_act, v2_act  out  DW each  active parameters to the DDA
pos_word  out  32  {x1[DW-1:DW-16], x2[DW-1:DW-16]} sampled
status_word  out  32  [31:30] state, [29:23] loaded mask, [22] err, [21] ack toggle, [15:0] sample count

Behaviour:
- Reset: all outputs 0; shadow registers 0; loaded mask 0; toggle history 0; sample divider = DIV_RESET; state IDLE.
- Command detect: cmd_valid is a 1-cycle pulse when cmd_word[23] differs from its registered previous value. On each accepted command, the ack bit takes the new toggle value one cycle after the toggle edge.
- Address map:
  - 0x02-0x08: write k1, k2, km, x1, v1, x2, v2 shadow, and set mask bit (addr-2).
  - 0x01: START.
  - 0x09: STOP.
  - 0x0A: set sample divider from data[DIV_W-1:0]; the value 0 is treated as 1.
  - 0x0B: clear err.
  - Any other address: set err. The command is still acked.
- State encoding: IDLE=0, RESTART=1, RUN=2, HOLD=3.
- IDLE:
  - START with mask==7'h7F: copy shadow to the *_act outputs in the same edge, load restart counter = RESTART_CYCLES, go to RESTART.
  - START with an incomplete mask: set err, stay in IDLE.
- RESTART:
  - dda_restart=1 for exactly RESTART_CYCLES cycles, then RUN with dda_restart=0.
  - Parameter writes update the shadow registers only.
  - START or STOP is ignored (acked, no err).
- RUN:
  - dda_run=1.
  - STOP: go to HOLD.
  - START: re-copy shadow and go to RESTART.
- HOLD:
  - dda_run=0; pos_word is frozen.
  - START: restart as in RUN.
  - STOP: no-op.
- The mask is never cleared except by reset. Once all seven parameters have been loaded, later STARTs reuse the current shadow contents.
- Sampler, RUN only:
  - The divider counter counts 0..div-1.
  - At terminal count, pos_word is updated from x1/x2 and the sample count increments, wrapping 16'hFFFF->0.
  - The divider counter clears on entry to RESTART.
  - A new divider value takes effect at the next terminal count or restart.
- Simultaneous events: only one command exists per cycle by construction. The err set by a bad address and a CLEAR_ERR cannot coincide.
- Reset mid-RESTART: dda_restart falls asynchronously, *_act outputs go to 0, state goes to IDLE.
- Width rule: pos_word fields are the top 16 bits of each position, truncated with no rounding.

Decomposition:
- Shared package dda_pkg: state encoding, command address constants (CMD_START=8'h01 ... CMD_CLR_ERR=8'h0B), mask-full constant 7'h7F, bit positions of cmd_word and status_word.
- One sub-module, dda_pos_sampler, holding the divider counter, pos_word register and sample counter. It has an enable input, a clear input and a div input.

Test Plan:
- After reset, write all seven parameters (k1=18'h10000, x1=18'h3C000, ...) then START -> mask=7'h7F; *_act equal the written values; dda_restart high for exactly 4 cycles; dda_run=1 from the following cycle.
- START after only six writes -> err=1, state IDLE, dda_restart never asserts; CLEAR_ERR (0x0B) -> err=0; ack toggles on each command.
- RUN with div=3 and x1=18'h3FFFC, x2=18'h00004 -> pos_word=32'hFFFF0001 every 3 cycles, sample count increments by 1 per update.
- In RUN, write k1=18'h20000 -> k1_act unchanged; STOP -> HOLD, dda_run=0, pos_word frozen; START -> k1_act=18'h20000 and a 4-cycle restart.
- Unknown address 0x20 -> err=1 and ack toggles; holding the toggle bit constant for 100 cycles -> no further command effects.
- Assert reset_n low during the second cycle of RESTART -> dda_restart, dda_run and *_act are all 0 immediately; state=IDLE; mask=0.
